// File: rtl/ppl_pkg.sv
// Shared constants and types for the ray-pipeline block-map access path.
package ppl_pkg;

  localparam int BLOCK_ADDR_W = 15;
  localparam int BLOCK_ID_W   = 5;
  localparam int LANE_IDX_W   = 3;

  // One return-tracking slot: marks a read in flight and the lane it belongs to.
  typedef struct packed {
    logic                  vld;
    logic [LANE_IDX_W-1:0] lane;
  } trk_t;

endpackage

// File: rtl/ppl_rr_arb.sv
// LANES-way rotating-priority arbiter: the first requester at or above ptr wins.
module ppl_rr_arb #(
  parameter int LANES = 4,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic [LANES-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [LANES-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < LANES; i++) begin
      j = int'(ptr) + i;
      if (j >= LANES) j = j - LANES;
      if (enable && !found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppl_block_arb.sv
// Shares the single-port block-map RAM between the pipeline read lanes and the
// world-edit write path; writes win but are spaced out during active display.
module ppl_block_arb
  import ppl_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int ADDR_W  = BLOCK_ADDR_W,
  parameter int ID_W    = BLOCK_ID_W,
  parameter int RAM_LAT = 1,
  parameter int WR_GAP  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vs,
  input  logic [LANES-1:0]        rd_req,
  input  logic [LANES*ADDR_W-1:0] rd_addr,
  output logic [LANES-1:0]        rd_gnt,
  output logic [LANES-1:0]        rd_valid,
  output logic [ID_W-1:0]         rd_data,
  input  logic                    wr_req,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [ID_W-1:0]         wr_data,
  output logic                    wr_gnt,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [ID_W-1:0]         ram_wdata,
  input  logic [ID_W-1:0]         ram_rdata
);

  localparam int IDX_W = $clog2(LANES);
  localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, arb_idx;
  logic [LANES-1:0]     arb_gnt;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 wr_elig, rd_any, rd_win;
  logic [ADDR_W-1:0]    rd_addr_sel;
  trk_t                 trk_in;
  trk_t [RAM_LAT:0]     trk_q;
  logic [LANES-1:0]     ret_onehot;

  logic [LANES-1:0]     rd_valid_q;
  logic [ID_W-1:0]      rd_data_q;
  logic                 ram_en_q, ram_we_q;
  logic [ADDR_W-1:0]    ram_addr_q;
  logic [ID_W-1:0]      ram_wdata_q;

  // Grant stage: writes pre-empt reads unless throttled during active display
  assign rd_any  = |rd_req;
  assign wr_elig = !rst && wr_req && (vs || !rd_any || (gap_cnt_q == '0));
  assign wr_gnt  = wr_elig;

  ppl_rr_arb #(.LANES(LANES), .IDX_W(IDX_W)) u_rr_arb (
    .req    (rd_req),
    .ptr    (rr_ptr_q),
    .enable (!rst && !wr_elig),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  assign rd_gnt      = arb_gnt;
  assign rd_win      = |arb_gnt;
  assign rd_addr_sel = rd_addr[int'(arb_idx)*ADDR_W +: ADDR_W];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    gap_cnt_d = gap_cnt_q;
    if (rd_win) rr_ptr_d = (arb_idx == IDX_W'(LANES-1)) ? '0 : arb_idx + 1'b1;
    if (wr_gnt)                 gap_cnt_d = GAP_W'(WR_GAP-1);
    else if (gap_cnt_q != '0)   gap_cnt_d = gap_cnt_q - 1'b1;
    trk_in.vld  = rd_win;
    trk_in.lane = LANE_IDX_W'(arb_idx);
  end

  always_comb begin
    ret_onehot = '0;
    for (int k = 0; k < LANES; k++)
      ret_onehot[k] = trk_q[RAM_LAT].vld && (trk_q[RAM_LAT].lane == LANE_IDX_W'(k));
  end

  // Issue stage and return pipeline: tracking slot RAM_LAT lines up with ram_rdata
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      trk_q       <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      gap_cnt_q <= gap_cnt_d;
      trk_q     <= {trk_q[RAM_LAT-1:0], trk_in};
      ram_en_q  <= wr_gnt | rd_win;
      ram_we_q  <= wr_gnt;
      if (wr_gnt) begin
        ram_addr_q  <= wr_addr;
        ram_wdata_q <= wr_data;
      end else if (rd_win) begin
        ram_addr_q  <= rd_addr_sel;
      end
      rd_valid_q <= ret_onehot;
      if (trk_q[RAM_LAT].vld) rd_data_q <= ram_rdata;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
